// File: rtl/nibble_serial_adder_ctrl.sv
// ----------------------------------------------------------------------------
// ripple_adder_4_bit_structural
//   Gate-level 4-bit ripple-carry adder (one full adder per bit).
//   a, b       : 4-bit addends
//   carry_in   : carry into bit 0
//   sum        : 4-bit sum
//   carry_out  : carry out of bit 3
// ----------------------------------------------------------------------------
module ripple_adder_4_bit_structural (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       carry_in,
   output logic [3:0] sum,
   output logic       carry_out
);

   logic [4:0] c;

   assign c[0] = carry_in;

   genvar i;
   generate
      for (i = 0; i < 4; i++) begin : g_fa
         assign sum[i]   = a[i] ^ b[i] ^ c[i];
         assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   endgenerate

   assign carry_out = c[4];

endmodule

// ----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//   Adds two WORDS*4-bit operands by feeding one nibble per clock (LSB first)
//   through a single shared 4-bit ripple adder, carrying between nibbles in a
//   register. Start/done handshake towards the host.
//   clk        : rising-edge clock
//   reset      : synchronous, active-high; aborts any operation in progress
//   start      : request, accepted only while ready=1
//   a, b       : operands, latched on an accepted start
//   carry_in   : initial carry, latched on an accepted start
//   ready      : high in IDLE and DONE
//   busy       : high in RUN
//   done       : one-cycle pulse when sum/carry_out hold a new result
//   sum        : registered W-bit result
//   carry_out  : registered carry out of the top nibble
// ----------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [4*WORDS-1:0]   a,
   input  logic [4*WORDS-1:0]   b,
   input  logic                 carry_in,
   output logic                 ready,
   output logic                 busy,
   output logic                 done,
   output logic [4*WORDS-1:0]   sum,
   output logic                 carry_out
);

   localparam int W     = 4 * WORDS;
   localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_next;
   logic [W-1:0]       opa, opb, acc, acc_next;
   logic               carry;
   logic [CNT_W-1:0]   count;
   logic               load, last;
   logic [3:0]         adder_sum;
   logic               adder_cout;

   ripple_adder_4_bit_structural u_adder (
      .a         (opa[3:0]),
      .b         (opb[3:0]),
      .carry_in  (carry),
      .sum       (adder_sum),
      .carry_out (adder_cout)
   );

   // New nibble enters at the top; after WORDS shifts the accumulator holds
   // the full result in the right order.
   assign acc_next = (acc >> 4) | (W'(adder_sum) << (W - 4));
   assign last     = (count == CNT_W'(WORDS - 1));

   always_comb begin
      state_next = state;
      ready      = 1'b0;
      busy       = 1'b0;
      done       = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            ready = 1'b1;
            done  = 1'b1;
            if (start) begin
               load       = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Control state and the host-visible result registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
      end else begin
         state <= state_next;
         if (load)
            count <= '0;
         else if (busy)
            count <= count + CNT_W'(1);
         if (busy && last) begin
            sum       <= acc_next;
            carry_out <= adder_cout;
         end
      end
   end

   // Operand shift registers, carry register and accumulator
   always_ff @(posedge clk) begin
      if (load) begin
         opa   <= a;
         opb   <= b;
         carry <= carry_in;
      end else if (busy) begin
         opa   <= opa >> 4;
         opb   <= opb >> 4;
         carry <= adder_cout;
         acc   <= acc_next;
      end
   end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
module tb_nibble_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        reset;

   logic        start4, cin4, ready4, busy4, done4, cout4;
   logic [15:0] a4, b4, sum4;

   logic        start1, cin1, ready1, busy1, done1, cout1;
   logic [3:0]  a1, b1, sum1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WORDS(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4),
      .carry_in(cin4), .ready(ready4), .busy(busy4), .done(done4),
      .sum(sum4), .carry_out(cout4)
   );

   nibble_serial_adder_ctrl #(.WORDS(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1),
      .carry_in(cin1), .ready(ready1), .busy(busy1), .done(done1),
      .sum(sum1), .carry_out(cout1)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] s;
      logic        co;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      tests++;
      fails++;
      $display("FAIL %s: no done within cycle budget", name);
   endtask

   // Called just after a falling edge; returns at the falling edge of the done cycle.
   task automatic run4(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic [15:0] s, output logic co, output int lat, output int nb);
      a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
      lat = 0; nb = 0;
      forever begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) break;
         if (busy4) nb++;
         lat++;
         if (lat > 40) begin timeout("run4"); break; end
      end
      s = sum4; co = cout4;
   endtask

   task automatic run1(input logic [3:0] a, input logic [3:0] b, input logic c,
                       output logic [3:0] s, output logic co, output int lat);
      a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
      lat = 0;
      forever begin
         @(negedge clk);
         start1 = 1'b0;
         if (done1) break;
         lat++;
         if (lat > 40) begin timeout("run1"); break; end
      end
      s = sum1; co = cout1;
   endtask

   initial begin
      logic [15:0] s;
      logic [3:0]  s1;
      logic        co;
      int          lat, nb, gap, ndone;
      logic [4:0]  exp5;

      vecs[0] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
      vecs[2] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
      vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
      vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
      vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
      vecs[7] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0};
      vecs[8] = '{16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1};

      reset = 1'b1;
      start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_ready", ready4, 1);
      chk("rst_busy",  busy4,  0);
      chk("rst_done",  done4,  0);
      chk("rst_sum",   sum4,   0);
      chk("rst_cout",  cout4,  0);
      chk("rst1_ready", ready1, 1);
      reset = 1'b0;
      @(negedge clk);

      // Table of single operations
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("v%0d_ready", i), ready4, 1);
         run4(vecs[i].a, vecs[i].b, vecs[i].cin, s, co, lat, nb);
         chk($sformatf("v%0d_sum", i),  s,   vecs[i].s);
         chk($sformatf("v%0d_cout", i), co,  vecs[i].co);
         chk($sformatf("v%0d_lat", i),  lat, 4);
         chk($sformatf("v%0d_busy", i), nb,  4);
         @(negedge clk);
         chk($sformatf("v%0d_idle_done", i), done4, 0);
         chk($sformatf("v%0d_hold_sum", i),  sum4,  vecs[i].s);
      end

      // start held high with operands changing during RUN
      a4 = 16'h1111; b4 = 16'h2222; cin4 = 1'b0; start4 = 1'b1;
      nb = 0; lat = 0;
      forever begin
         @(negedge clk);
         if (done4) begin start4 = 1'b0; break; end
         if (busy4) nb++;
         a4 = a4 + 16'h0101; b4 = ~b4; cin4 = ~cin4;
         lat++;
         if (lat > 40) begin timeout("hold_start"); break; end
      end
      chk("hold_busy_cycles", nb, 4);
      chk("hold_sum",  sum4,  16'h3333);
      chk("hold_cout", cout4, 0);
      @(negedge clk);
      chk("hold_idle_busy",  busy4,  0);
      chk("hold_idle_ready", ready4, 1);

      // Reset in the middle of RUN
      a4 = 16'h00FF; b4 = 16'h0001; cin4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      chk("abort_busy_before", busy4, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_ready", ready4, 1);
      chk("abort_busy",  busy4,  0);
      chk("abort_done",  done4,  0);
      chk("abort_sum",   sum4,   0);
      chk("abort_cout",  cout4,  0);
      ndone = 0;
      repeat (6) begin
         @(negedge clk);
         if (done4) ndone++;
      end
      chk("abort_no_done", ndone, 0);
      run4(16'h00FF, 16'h0001, 1'b0, s, co, lat, nb);
      chk("after_abort_sum", s, 16'h0100);
      chk("after_abort_lat", lat, 4);
      @(negedge clk);

      // Back-to-back: new start in the DONE cycle
      run4(16'h0010, 16'h0020, 1'b0, s, co, lat, nb);
      chk("b2b_first_sum", s, 16'h0030);
      a4 = 16'h0003; b4 = 16'h0006; cin4 = 1'b0; start4 = 1'b1;
      gap = 0;
      forever begin
         @(negedge clk);
         start4 = 1'b0;
         gap++;
         if (done4) break;
         chk($sformatf("b2b_hold_%0d", gap), sum4, 16'h0030);
         if (gap > 40) begin timeout("b2b"); break; end
      end
      chk("b2b_gap",  gap,   5);
      chk("b2b_sum",  sum4,  16'h0009);
      chk("b2b_cout", cout4, 0);
      @(negedge clk);

      // WORDS=1, every operand pair and carry
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            for (int c = 0; c < 2; c++) begin
               run1(4'(x), 4'(y), 1'(c), s1, co, lat);
               exp5 = 5'(x + y + c);
               chk($sformatf("w1_%0d_%0d_%0d", x, y, c), {co, s1}, exp5);
               chk($sformatf("w1_lat_%0d_%0d_%0d", x, y, c), lat, 1);
               @(negedge clk);
            end
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
